// File: rtl/serial_queue_pkg.sv
// Shared types and default configuration for the serial-to-queue bridge.
package serial_queue_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_DES_DIV = 10;
  localparam int unsigned DEF_Q_DIV   = 100;

  typedef enum logic {
    SHIFT = 1'b0,
    HOLD  = 1'b1
  } des_state_t;

endpackage

// File: rtl/serial_queue_bridge_tick_gen.sv
// One-cycle enable every DIV clocks from a free-running 0..DIV-1 counter.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count, wrapping at DIV-1
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_W'(DIV - 1)) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_W'(DIV - 1));

endmodule

// File: rtl/serial_queue_bridge.sv
// Serial deserializer feeding a circular queue; both paced by tick enables.
// Optional sticky error flags (err_out) when SERIAL_QUEUE_ERR_EN is defined.
module serial_queue_bridge
  import serial_queue_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned DES_DIV = DEF_DES_DIV,
  parameter int unsigned Q_DIV   = DEF_Q_DIV
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       enqueue_in,
  input  logic                       dequeue_in,
  output logic                       status_out,
  output logic                       data_ready,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic [DATA_W-1:0]          data_out
`ifdef SERIAL_QUEUE_ERR_EN
  ,
  output logic [1:0]                 err_out
`endif
);

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  logic des_tick, q_tick;

  tick_gen #(.DIV(DES_DIV)) u_des_tick (
    .clock (clock),
    .reset (reset),
    .tick  (des_tick)
  );

  tick_gen #(.DIV(Q_DIV)) u_q_tick (
    .clock (clock),
    .reset (reset),
    .tick  (q_tick)
  );

  des_state_t        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              ack_q, ack_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic full, empty, enq_fire, deq_fire;

  assign full     = (len_q == LEN_W'(DEPTH));
  assign empty    = (len_q == '0);
  // A held enqueue while full waits for a later q_tick, even if a dequeue frees a slot now
  assign enq_fire = q_tick && (state_q == HOLD) && enqueue_in && !full;
  assign deq_fire = q_tick && dequeue_in && !empty;

  // Deserializer next-state: shift accepted bits, freeze word until acknowledged
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (state_q == SHIFT) begin
      if (des_tick && write_in) begin
        shift_d = {shift_q[DATA_W-2:0], data_in};
        if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
          bitcnt_d = '0;
          state_d  = HOLD;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
    end else begin
      if (ack_q) state_d = SHIFT;
    end
  end

  // Queue pointer, occupancy and output word updates
  always_comb begin
    ack_d    = enq_fire;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    dout_d   = dout_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    if (enq_fire && !deq_fire) len_d = len_q + 1'b1;
    if (!enq_fire && deq_fire) len_d = len_q - 1'b1;
  end

  // Control and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= SHIFT;
      shift_q  <= '0;
      bitcnt_q <= '0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      dout_q   <= dout_d;
    end
  end

  // Queue storage; contents are meaningless after reset since pointers clear
  always_ff @(posedge clock) begin
    if (enq_fire) mem_q[wr_ptr_q] <= shift_q;
  end

  assign status_out = (state_q == SHIFT);
  assign data_ready = (state_q == HOLD);
  assign len_out    = len_q;
  assign data_out   = dout_q;

`ifdef SERIAL_QUEUE_ERR_EN
  logic [1:0] err_q, err_d;

  // Sticky flags: bit0 enqueue attempted while full, bit1 dequeue while empty
  always_comb begin
    err_d = err_q;
    if (q_tick && data_ready && enqueue_in && full) err_d[0] = 1'b1;
    if (q_tick && dequeue_in && empty)              err_d[1] = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_out = err_q;
`endif

endmodule

// File: tb/tb_serial_queue_bridge.sv
// Directed scoreboard bench for serial_queue_bridge (default and 12x4 instances).
module tb_serial_queue_bridge;

  localparam int A_DES = 10;
  localparam int A_Q   = 100;
  localparam int B_DES = 4;
  localparam int B_Q   = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic       a_data_in = 1'b0, a_write_in = 1'b0, a_enq = 1'b0, a_deq = 1'b0;
  logic       a_status, a_ready;
  logic [3:0] a_len;
  logic [7:0] a_dout;

  logic        b_data_in = 1'b0, b_write_in = 1'b0, b_enq = 1'b0, b_deq = 1'b0;
  logic        b_status, b_ready;
  logic [2:0]  b_len;
  logic [11:0] b_dout;

`ifdef SERIAL_QUEUE_ERR_EN
  logic [1:0] a_err, b_err;
`endif

  serial_queue_bridge #(
    .DATA_W(8), .DEPTH(8), .DES_DIV(A_DES), .Q_DIV(A_Q)
  ) dut_a (
    .clock      (clock),
    .reset      (reset),
    .data_in    (a_data_in),
    .write_in   (a_write_in),
    .enqueue_in (a_enq),
    .dequeue_in (a_deq),
    .status_out (a_status),
    .data_ready (a_ready),
    .len_out    (a_len),
    .data_out   (a_dout)
`ifdef SERIAL_QUEUE_ERR_EN
    ,
    .err_out    (a_err)
`endif
  );

  serial_queue_bridge #(
    .DATA_W(12), .DEPTH(4), .DES_DIV(B_DES), .Q_DIV(B_Q)
  ) dut_b (
    .clock      (clock),
    .reset      (reset),
    .data_in    (b_data_in),
    .write_in   (b_write_in),
    .enqueue_in (b_enq),
    .dequeue_in (b_deq),
    .status_out (b_status),
    .data_ready (b_ready),
    .len_out    (b_len),
    .data_out   (b_dout)
`ifdef SERIAL_QUEUE_ERR_EN
    ,
    .err_out    (b_err)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference tick phase: free-running counters restarted by reset
  int a_des_cnt, a_q_cnt, b_des_cnt, b_q_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_des_cnt <= 0; a_q_cnt <= 0; b_des_cnt <= 0; b_q_cnt <= 0;
    end else begin
      a_des_cnt <= (a_des_cnt == A_DES - 1) ? 0 : a_des_cnt + 1;
      a_q_cnt   <= (a_q_cnt   == A_Q   - 1) ? 0 : a_q_cnt + 1;
      b_des_cnt <= (b_des_cnt == B_DES - 1) ? 0 : b_des_cnt + 1;
      b_q_cnt   <= (b_q_cnt   == B_Q   - 1) ? 0 : b_q_cnt + 1;
    end
  end

  logic [11:0] sb[$];

  function automatic bit tick_now(input int sel);
    case (sel)
      0:       return a_des_cnt == A_DES - 1;
      1:       return a_q_cnt   == A_Q   - 1;
      2:       return b_des_cnt == B_DES - 1;
      default: return b_q_cnt   == B_Q   - 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the tick edge
  task automatic wait_tick(input int sel);
    while (!tick_now(sel)) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic send_bit_a(input logic b);
    a_data_in = b; a_write_in = 1'b1;
    wait_tick(0);
    a_write_in = 1'b0;
  endtask

  task automatic send_word_a(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit_a(w[i]);
  endtask

  task automatic enq_a(input logic [7:0] w);
    a_enq = 1'b1;
    wait_tick(1);
    a_enq = 1'b0;
    sb.push_back({4'h0, w});
    repeat (3) @(negedge clock);
  endtask

  task automatic deq_a(input string tag);
    logic [11:0] e;
    a_deq = 1'b1;
    wait_tick(1);
    a_deq = 1'b0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check(tag, {24'h0, a_dout}, {20'h0, e});
    end
  endtask

  task automatic send_word_b(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) begin
      b_data_in = w[i]; b_write_in = 1'b1;
      wait_tick(2);
      b_write_in = 1'b0;
    end
  endtask

  task automatic enq_b(input logic [11:0] w);
    b_enq = 1'b1;
    wait_tick(3);
    b_enq = 1'b0;
    sb.push_back(w);
    repeat (3) @(negedge clock);
  endtask

  task automatic deq_b(input string tag);
    logic [11:0] e;
    b_deq = 1'b1;
    wait_tick(3);
    b_deq = 1'b0;
    e = sb.pop_front();
    check(tag, {20'h0, b_dout}, {20'h0, e});
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    #22;
    check("rst_status", a_status, 1);
    check("rst_ready",  a_ready,  0);
    check("rst_len",    a_len,    0);
    check("rst_dout",   a_dout,   0);
`ifdef SERIAL_QUEUE_ERR_EN
    check("rst_err", a_err, 0);
`endif
    @(negedge clock); reset = 1'b1;

    // Single word A5
    for (int i = 7; i >= 1; i--) send_bit_a(8'hA5 >> i);
    check("seven_bits_status", a_status, 1);
    send_bit_a(1'b1);
    check("a5_ready",  a_ready,  1);
    check("a5_status", a_status, 0);
    enq_a(8'hA5);
    check("a5_len",        a_len,    1);
    check("a5_back_shift", a_status, 1);
    deq_a("a5_dout");
    check("a5_len_after", a_len, 0);

    // Dequeue while empty
    a_deq = 1'b1; wait_tick(1); a_deq = 1'b0;
    check("empty_len",  a_len,  0);
    check("empty_dout", a_dout, 8'hA5);
`ifdef SERIAL_QUEUE_ERR_EN
    check("empty_err", a_err, 2'b10);
`endif

    // Fill to DEPTH, ninth word held
    for (int i = 0; i < 8; i++) begin
      w = 8'h11 + 8'(i);
      send_word_a(w);
      enq_a(w);
      check($sformatf("fill_len%0d", i), a_len, i + 1);
    end
    send_word_a(8'h19);
    a_enq = 1'b1;
    wait_tick(1);
    check("full_len",   a_len,   8);
    check("full_ready", a_ready, 1);
    for (int i = 0; i < 3; i++) send_bit_a(1'b0);
    check("hold_ignores_bits", a_ready, 1);
    a_deq = 1'b1;
    wait_tick(1);
    a_deq = 1'b0;
    begin
      logic [11:0] e;
      e = sb.pop_front();
      check("full_deq_dout", a_dout, e);
    end
    check("full_deq_len", a_len, 7);
    wait_tick(1);
    a_enq = 1'b0;
    sb.push_back(12'h019);
    check("ninth_len", a_len, 8);
`ifdef SERIAL_QUEUE_ERR_EN
    check("full_err", a_err, 2'b11);
`endif
    repeat (3) @(negedge clock);
    check("ninth_shift", a_status, 1);
    for (int i = 0; i < 8; i++) deq_a($sformatf("drain%0d", i));
    check("drain_len", a_len, 0);

    // 20 words streamed with simultaneous enqueue/dequeue across pointer wrap
    for (int i = 0; i < 20; i++) begin
      w = 8'h40 + 8'(i);
      send_word_a(w);
      a_enq = 1'b1;
      if (i >= 4) a_deq = 1'b1;
      wait_tick(1);
      a_enq = 1'b0;
      if (i >= 4) begin
        logic [11:0] e;
        a_deq = 1'b0;
        e = sb.pop_front();
        check($sformatf("stream%0d", i), a_dout, e);
      end
      sb.push_back({4'h0, w});
      check($sformatf("stream_len%0d", i), a_len, (i < 4) ? i + 1 : 4);
      repeat (3) @(negedge clock);
    end
    for (int i = 0; i < 4; i++) deq_a($sformatf("tail%0d", i));

    // Reset mid-word with three entries queued
    for (int i = 0; i < 3; i++) begin
      w = 8'h70 + 8'(i);
      send_word_a(w);
      enq_a(w);
    end
    check("pre_reset_len", a_len, 3);
    for (int i = 0; i < 5; i++) send_bit_a(1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_len",    a_len,    0);
    check("mid_rst_dout",   a_dout,   0);
    check("mid_rst_status", a_status, 1);
    check("mid_rst_ready",  a_ready,  0);
`ifdef SERIAL_QUEUE_ERR_EN
    check("mid_rst_err", a_err, 0);
`endif
    sb.delete();
    @(negedge clock); reset = 1'b1;
    send_word_a(8'h3C);
    enq_a(8'h3C);
    check("fresh_len", a_len, 1);
    deq_a("fresh_dout");

    // 12-bit, depth-4 instance
    send_word_b(12'hABC);
    check("b_ready", b_ready, 1);
    enq_b(12'hABC);
    check("b_len1", b_len, 1);
    send_word_b(12'h123);
    enq_b(12'h123);
    check("b_len2", b_len, 2);
    deq_b("b_abc");
    deq_b("b_123");
    check("b_len0", b_len, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
